// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between I-cache and D-cache with alternating priority on conflict.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              I_read,
  input  logic              I_write,
  input  logic [ADDR_W-1:0] I_addr,
  input  logic [DATA_W-1:0] I_wdata,
  output logic [DATA_W-1:0] I_rdata,
  output logic              I_ready,
  input  logic              D_read,
  input  logic              D_write,
  input  logic [ADDR_W-1:0] D_addr,
  input  logic [DATA_W-1:0] D_wdata,
  output logic [DATA_W-1:0] D_rdata,
  output logic              D_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
  state_t state;
  logic last_d;
  logic i_req, d_req, pick_d;
  assign i_req = I_read | I_write;
  assign d_req = D_read | D_write;
  // D wins unless I is also asking and D was the most recent owner
  assign pick_d = d_req & (~i_req | ~last_d);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      grant     <= 2'b00;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      I_ready   <= 1'b0;
      D_ready   <= 1'b0;
      I_rdata   <= '0;
      D_rdata   <= '0;
    end else begin
      case (state)
        IDLE: if (i_req | d_req) begin
          state     <= pick_d ? BUSY_D : BUSY_I;
          grant     <= pick_d ? 2'b10 : 2'b01;
          mem_addr  <= pick_d ? D_addr : I_addr;
          mem_wdata <= pick_d ? D_wdata : I_wdata;
          mem_write <= pick_d ? D_write : I_write;
          mem_read  <= pick_d ? (D_read & ~D_write) : (I_read & ~I_write);
        end
        BUSY_I: if (mem_ready) begin
          state     <= DONE;
          I_rdata   <= mem_rdata;
          I_ready   <= 1'b1;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          last_d    <= 1'b0;
        end
        BUSY_D: if (mem_ready) begin
          state     <= DONE;
          D_rdata   <= mem_rdata;
          D_ready   <= 1'b1;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          last_d    <= 1'b1;
        end
        DONE: begin
          state   <= IDLE;
          grant   <= 2'b00;
          I_ready <= 1'b0;
          D_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, issue timing, write priority and async reset.
module tb_mem_arbiter;
  logic         clk = 0;
  logic         rst_n = 0;
  logic         I_read = 0, I_write = 0, D_read = 0, D_write = 0;
  logic [27:0]  I_addr = 0, D_addr = 0;
  logic [127:0] I_wdata = 0, D_wdata = 0, mem_rdata = 0;
  logic         mem_ready = 0;
  logic [127:0] I_rdata, D_rdata, mem_wdata;
  logic         I_ready, D_ready, mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [1:0]   grant;
  int checks = 0, errors = 0;

  mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .I_read(I_read), .I_write(I_write), .I_addr(I_addr), .I_wdata(I_wdata),
    .I_rdata(I_rdata), .I_ready(I_ready),
    .D_read(D_read), .D_write(D_write), .D_addr(D_addr), .D_wdata(D_wdata),
    .D_rdata(D_rdata), .D_ready(D_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_cmd"}, {mem_read, mem_write}, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_ready"}, {D_ready, I_ready}, 0);
    chk({tag, "_i_rdata"}, I_rdata, 0);
    chk({tag, "_d_rdata"}, D_rdata, 0);
  endtask

  // one full transaction from the IDLE cycle where the request is already driven
  task automatic serve(input logic [1:0] g, input logic [27:0] a, input logic w,
                       input logic [127:0] wd, input logic [127:0] rd, input int wait_n);
    tick;
    chk("issue_grant", grant, g);
    chk("issue_addr", mem_addr, a);
    chk("issue_cmd", {mem_read, mem_write}, {~w, w});
    chk("issue_wdata", mem_wdata, wd);
    for (int i = 0; i < wait_n; i++) begin
      tick;
      chk("busy_cmd", {mem_read, mem_write}, {~w, w});
      chk("busy_ready", {D_ready, I_ready}, 0);
    end
    mem_ready = 1;
    mem_rdata = rd;
    tick;
    mem_ready = 0;
    chk("done_ready", {D_ready, I_ready}, g);
    chk("done_rdata", g == 2'b01 ? I_rdata : D_rdata, rd);
    chk("done_cmd", {mem_read, mem_write}, 0);
    chk("done_grant", grant, g);
    tick;
    chk("idle_ready", {D_ready, I_ready}, 0);
    chk("idle_grant", grant, 0);
  endtask

  initial begin
    #1;
    all_zero("reset");
    tick;
    rst_n = 1;
    tick;
    mem_ready = 1;
    mem_rdata = 128'h5555;
    tick;
    mem_ready = 0;
    chk("spurious_grant", grant, 0);
    chk("spurious_ready", {D_ready, I_ready}, 0);
    chk("spurious_rdata", I_rdata, 0);
    tick;
    chk("spurious_idle", {mem_read, mem_write, grant}, 0);

    I_read = 1;
    I_addr = 28'h0000010;
    serve(2'b01, 28'h0000010, 1'b0, 128'h0, 128'hDEADBEEF, 3);
    I_read = 0;
    tick;
    chk("i_rdata_hold", I_rdata, 128'hDEADBEEF);
    chk("d_ready_quiet", D_ready, 0);

    rst_n = 0;
    #1;
    chk("reset_rdata", I_rdata, 0);
    tick;
    rst_n = 1;

    I_read = 1; I_addr = 28'h100;
    D_read = 1; D_addr = 28'h200;
    serve(2'b10, 28'h200, 1'b0, 128'h0, 128'hD1, 0);
    serve(2'b01, 28'h100, 1'b0, 128'h0, 128'hA1, 1);
    serve(2'b10, 28'h200, 1'b0, 128'h0, 128'hD2, 0);
    serve(2'b01, 28'h100, 1'b0, 128'h0, 128'hA2, 2);
    I_read = 0; D_read = 0;
    tick;
    chk("alt_idle", grant, 0);

    D_read = 1; D_write = 1; D_addr = 28'h33; D_wdata = 128'h1234;
    serve(2'b10, 28'h33, 1'b1, 128'h1234, 128'h77, 1);
    D_read = 0; D_write = 0; D_wdata = 0;
    tick;

    D_read = 1; D_addr = 28'h44;
    tick;
    chk("pre_rst_grant", grant, 2'b10);
    chk("pre_rst_cmd", mem_read, 1);
    #2;
    rst_n = 0;
    #1;
    all_zero("async");
    mem_ready = 1;
    tick;
    mem_ready = 0;
    rst_n = 1;
    chk("post_rst_ready", {D_ready, I_ready}, 0);
    serve(2'b10, 28'h44, 1'b0, 128'h0, 128'h99, 1);
    D_read = 0;
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
